// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory, buffers responses in a small in-order queue and presents the head
// entry to the IF/ID register. Execute-stage redirects flush the queue and
// retarget fetch; a response already in flight when a redirect hits is dropped.
//
// Handshakes: imem_req/imem_addr hold steady until imem_ack is seen high on a
// rising edge; exactly one response (imem_rvalid) then follows, earliest one
// cycle after the ack. Decode consumes the head entry on any edge where
// if_valid=1 and id_stall=0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int          PW    = (QDEPTH > 2) ? 2 : 1;
    localparam int          CW    = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic          drop;
    logic [CW-1:0] count;
    logic [PW-1:0] head, tail;
    logic [31:0]   pc_mem   [QDEPTH];
    logic [31:0]   inst_mem [QDEPTH];
    logic          issue, resp, push, pop;

    // Redirect targets are forced word-aligned, so the low two bits never matter.
    logic unused_bits;
    assign unused_bits = ^redirect_pc[1:0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode plus the issue/response/queue strobes it implies.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        resp       = 1'b0;
        case (state)
            S_IDLE: begin
                if (count < DEPTH && !redirect) begin
                    state_next = S_REQ;
                    issue      = 1'b1;
                end
            end
            S_REQ: begin
                if (imem_ack) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_next = S_IDLE;
                    resp       = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        push = resp && !drop && !redirect;
        pop  = if_valid && !id_stall && !redirect;
    end

    // Registered memory request; the address is latched only when a fetch starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
        end else begin
            imem_req <= (state_next == S_REQ);
            if (issue) imem_addr <= fetch_pc;
        end
    end

    // Fetch PC and drop flag: redirect retargets, a kept response advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            drop     <= 1'b0;
        end else begin
            if (redirect)  fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (push) fetch_pc <= fetch_pc + 32'd4;
            // A response still owed after this edge belongs to the old path.
            if (redirect && (state == S_REQ || (state == S_WAIT && !imem_rvalid)))
                drop <= 1'b1;
            else if (resp)
                drop <= 1'b0;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Queue storage: entries are written at the tail with the PC they were fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            inst_mem[tail] <= imem_rdata;
        end
    end

    assign if_valid  = (count != '0);
    assign if_inst   = if_valid ? inst_mem[head] : NOP;
    assign if_pc     = if_valid ? pc_mem[head]   : 32'h0;
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed memory transactions, an expected queue of
// {pc, inst} pairs filled as responses are driven, and a monitor that checks
// the presented head entry against the queue every cycle it is valid.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL wait_req: got imem_req=0 expected 1 within 20 cycles");
        end
    endtask

    // One fetch: ack in the request cycle, response the cycle after.
    task automatic fetch_one(input logic [31:0] data, input bit keep);
        logic [31:0] addr;
        wait_req();
        addr     = imem_addr;
        imem_ack = 1'b1;
        tick();
        imem_ack    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        if (keep) exp_q.push_back({addr, data});
        tick();
        imem_rvalid = 1'b0;
    endtask

    // Monitor: whenever a real instruction is presented it must equal the oldest expected one.
    always @(negedge clk) begin
        if (!reset && if_valid && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head: got pc=%h inst=%h expected no entry", if_pc, if_inst);
            end else begin
                check("head", {if_pc, if_inst}, exp_q[0]);
                if (!id_stall) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset values.
        tick(); tick(); tick();
        check("rst_req",   {63'h0, imem_req}, 64'h0);
        check("rst_addr",  {32'h0, imem_addr}, 64'h0);
        check("rst_valid", {63'h0, if_valid}, 64'h0);
        check("rst_inst",  {32'h0, if_inst}, 64'h13);
        check("rst_pc",    {32'h0, if_pc}, 64'h0);
        check("rst_state", {62'h0, dbg_state}, 64'h0);
        reset = 1'b0;

        // First fetch right after release.
        tick();
        check("first_req",  {63'h0, imem_req}, 64'h1);
        check("first_addr", {32'h0, imem_addr}, 64'h0);
        fetch_one(32'h0050_0093, 1'b1);
        check("first_valid", {63'h0, if_valid}, 64'h1);
        check("first_pc",    {32'h0, if_pc}, 64'h0);
        check("first_inst",  {32'h0, if_inst}, 64'h0050_0093);
        tick();
        check("second_addr", {32'h0, imem_addr}, 64'h4);

        // Stalled decode: queue fills to depth 2, fetch stops, head holds.
        id_stall = 1'b1;
        fetch_one(32'h1111_0004, 1'b1);
        fetch_one(32'h2222_0008, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_req",  {63'h0, imem_req}, 64'h0);
            check("full_hold", {if_pc, if_inst}, {32'h4, 32'h1111_0004});
        end
        id_stall = 1'b0;

        // Redirect while waiting for the response: that response is dropped.
        wait_req();
        check("pre_redir_addr", {32'h0, imem_addr}, 64'hC);
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0103; exp_q.delete();
        tick();
        redirect = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("drop_valid", {63'h0, if_valid}, 64'h0);
        wait_req();
        check("redir_addr", {32'h0, imem_addr}, 64'h100);
        fetch_one(32'h0000_0100, 1'b1);
        check("redir_pc", {32'h0, if_pc}, 64'h100);
        tick();

        // Redirect coinciding with a response while one entry is queued.
        id_stall = 1'b1;
        fetch_one(32'h0000_0104, 1'b1);
        wait_req();
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0108;
        redirect = 1'b1; redirect_pc = 32'h0000_2000; exp_q.delete();
        tick();
        imem_rvalid = 1'b0; redirect = 1'b0; id_stall = 1'b0;
        check("flush_valid", {63'h0, if_valid}, 64'h0);
        check("flush_inst",  {32'h0, if_inst}, 64'h13);
        check("flush_pc",    {32'h0, if_pc}, 64'h0);
        wait_req();
        check("same_cyc_addr", {32'h0, imem_addr}, 64'h2000);
        fetch_one(32'h0000_2000, 1'b1);

        // Redirect in IDLE to the top word (unaligned target): no issue that cycle, then wrap.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; exp_q.delete();
        tick();
        redirect = 1'b0;
        check("idle_redir_req", {63'h0, imem_req}, 64'h0);
        wait_req();
        check("top_addr", {32'h0, imem_addr}, 64'hFFFF_FFFC);
        fetch_one(32'hFFFF_0001, 1'b1);
        wait_req();
        check("wrap_addr", {32'h0, imem_addr}, 64'h0);
        fetch_one(32'h0000_0002, 1'b1);

        // Two redirects while the request is pending: one response dropped, last target wins.
        wait_req();
        check("pend_addr", {32'h0, imem_addr}, 64'h4);
        redirect = 1'b1; redirect_pc = 32'h0000_0300; exp_q.delete();
        tick();
        redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        check("hold_req",  {63'h0, imem_req}, 64'h1);
        check("hold_addr", {32'h0, imem_addr}, 64'h4);
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0004;
        tick();
        imem_rvalid = 1'b0;
        check("dbl_drop_valid", {63'h0, if_valid}, 64'h0);
        wait_req();
        check("dbl_redir_addr", {32'h0, imem_addr}, 64'h400);
        fetch_one(32'h0000_0400, 1'b1);
        check("dbl_redir_pc", {32'h0, if_pc}, 64'h400);

        // Asynchronous reset during a pending request.
        wait_req();
        reset = 1'b1; exp_q.delete();
        #1;
        check("async_req",   {63'h0, imem_req}, 64'h0);
        check("async_addr",  {32'h0, imem_addr}, 64'h0);
        check("async_state", {62'h0, dbg_state}, 64'h0);
        tick();
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
        tick();
        imem_rvalid = 1'b0;
        check("post_rst_req",   {63'h0, imem_req}, 64'h1);
        check("post_rst_addr",  {32'h0, imem_addr}, 64'h0);
        check("post_rst_valid", {63'h0, if_valid}, 64'h0);
        fetch_one(32'h00A0_0113, 1'b1);
        check("post_rst_pc",   {32'h0, if_pc}, 64'h0);
        check("post_rst_inst", {32'h0, if_inst}, 64'h00A0_0113);

        // Drain and confirm every expected entry was presented.
        tick(); tick(); tick();
        check("drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
